// File: rtl/seletor_modo.sv
// rtl/seletor_modo.sv - two-button mode sequencer driving the {SW2,SW1,SW0} mode code (optional inactivity exit: SELETOR_AUTO_EXIT_EN)
module seletor_modo #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter int AUTO_EXIT_CYCLES  = 500000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_modo,
    input  logic btn_ajuste,
    output logic SW2,
    output logic SW1,
    output logic SW0,
    output logic pulso_saida_ajuste
);

    // State encoding is the mode code itself, so the outputs come straight from the state flops.
    typedef enum logic [2:0] {
        RELOGIO        = 3'b000,
        CRONOMETRO     = 3'b001,
        TIMER          = 3'b010,
        AJUSTE_RELOGIO = 3'b100,
        AJUSTE_TIMER   = 3'b110
    } estado_t;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    // Bit 0 is the mode button, bit 1 the adjust button.
    logic [1:0]           raw;
    logic [1:0]           sync1;
    logic [1:0]           sync2;
    logic [1:0]           sync_valid;
    logic [1:0]           stable;
    logic [1:0]           stable_d;
    logic [1:0]           armed;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           rise;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 long_evt;
    logic                 auto_exit;
    logic                 pulso_next;
    estado_t              estado;
    estado_t              estado_next;

    assign raw = {btn_ajuste, btn_modo};

    // Synchronize, debounce and arm each button; a button is armed once its real level has been seen low after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sync_valid <= '0;
            stable     <= '0;
            stable_d   <= '0;
            armed      <= '0;
            db_cnt     <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            stable_d   <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                armed[i] <= armed[i] | (sync_valid[1] & ~sync2[i] & ~stable[i]);
            end
        end
    end

    // A press held through reset is never seen as a rise or a long press.
    assign rise     = stable & ~stable_d & armed;
    assign long_evt = stable[1] & armed[1] & (hold_cnt == HOLD_LAST);

    // Saturating hold timer for the debounced adjust button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (!stable[1]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

`ifdef SELETOR_AUTO_EXIT_EN
    localparam int AX_W = $clog2(AUTO_EXIT_CYCLES + 1);
    localparam logic [AX_W-1:0] AX_LAST = AX_W'(AUTO_EXIT_CYCLES - 1);

    logic [AX_W-1:0] idle_cnt;
    logic            em_ajuste;
    logic            nivel_mudou;

    assign em_ajuste   = (estado == AJUSTE_RELOGIO) || (estado == AJUSTE_TIMER);
    assign nivel_mudou = |(stable ^ stable_d);
    assign auto_exit   = em_ajuste && (idle_cnt == AX_LAST);

    // Inactivity timer: idle at zero outside adjust, restarted by any debounced button change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!em_ajuste || nivel_mudou || auto_exit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + AX_W'(1);
        end
    end
`else
    // Timeout parameter has no effect in this build; adjust modes are left only by a press or reset.
    assign auto_exit = 1'b0 & (AUTO_EXIT_CYCLES == 0);
`endif

    // Mode state and exit pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado             <= RELOGIO;
            pulso_saida_ajuste <= 1'b0;
        end else begin
            estado             <= estado_next;
            pulso_saida_ajuste <= pulso_next;
        end
    end

    // Next mode: adjust events take priority over a mode rise in the same cycle.
    always_comb begin
        estado_next = estado;
        pulso_next  = 1'b0;
        case (estado)
            RELOGIO: begin
                if (long_evt)     estado_next = AJUSTE_RELOGIO;
                else if (rise[0]) estado_next = CRONOMETRO;
            end
            CRONOMETRO: begin
                if (rise[0]) estado_next = TIMER;
            end
            TIMER: begin
                if (long_evt)     estado_next = AJUSTE_TIMER;
                else if (rise[0]) estado_next = RELOGIO;
            end
            AJUSTE_RELOGIO: begin
                if (rise[1] || auto_exit) begin
                    estado_next = RELOGIO;
                    pulso_next  = 1'b1;
                end
            end
            AJUSTE_TIMER: begin
                if (rise[1] || auto_exit) begin
                    estado_next = TIMER;
                    pulso_next  = 1'b1;
                end
            end
            default: estado_next = RELOGIO;
        endcase
    end

    assign SW2 = estado[2];
    assign SW1 = estado[1];
    assign SW0 = estado[0];

endmodule

// File: tb/tb_seletor_modo.sv
// tb/tb_seletor_modo.sv - directed self-checking bench for seletor_modo (SELETOR_AUTO_EXIT_EN selects the timeout case)
module tb_seletor_modo;

    localparam int D = 4;
    localparam int L = 16;
    localparam int A = 32;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic btn_modo   = 1'b0;
    logic btn_ajuste = 1'b0;
    logic SW2;
    logic SW1;
    logic SW0;
    logic pulso_saida_ajuste;

    int n_checks  = 0;
    int n_pass    = 0;
    int pulse_cnt = 0;
    int p0;

    seletor_modo #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .AUTO_EXIT_CYCLES (A)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_modo          (btn_modo),
        .btn_ajuste        (btn_ajuste),
        .SW2               (SW2),
        .SW1               (SW1),
        .SW0               (SW0),
        .pulso_saida_ajuste(pulso_saida_ajuste)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pulso_saida_ajuste === 1'b1) pulse_cnt++;
    end

    function automatic logic [31:0] code();
        return {29'd0, SW2, SW1, SW0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_modo(input int hold, input int gap);
        btn_modo = 1'b1;
        wait_n(hold);
        btn_modo = 1'b0;
        wait_n(gap);
    endtask

    task automatic press_ajuste(input int hold, input int gap);
        btn_ajuste = 1'b1;
        wait_n(hold);
        btn_ajuste = 1'b0;
        wait_n(gap);
    endtask

    // Short adjust press out of an adjust mode: code flips and pulse shows on the 7th edge only.
    task automatic exit_adj(input string tag, input logic [31:0] from, input logic [31:0] to);
        int pc;
        pc = pulse_cnt;
        btn_ajuste = 1'b1;
        wait_n(6);
        check({tag, "_before"}, code(), from);
        wait_n(1);
        check({tag, "_code"}, code(), to);
        check({tag, "_pulse"}, 32'(pulso_saida_ajuste), 32'd1);
        wait_n(1);
        check({tag, "_pulse_end"}, 32'(pulso_saida_ajuste), 32'd0);
        wait_n(2);
        btn_ajuste = 1'b0;
        wait_n(10);
        check({tag, "_one_pulse"}, 32'(pulse_cnt - pc), 32'd1);
    endtask

    initial begin
        wait_n(3);
        check("rst_code", code(), 32'd0);
        check("rst_pulse", 32'(pulso_saida_ajuste), 32'd0);
        reset = 1'b0;
        wait_n(5);

        // Mid-run async reset
        press_modo(10, 10);
        check("pre_run", code(), 32'd1);
        #2 reset = 1'b1;
        #1 check("async_rst_code", code(), 32'd0);
        check("async_rst_pulse", 32'(pulso_saida_ajuste), 32'd0);
        wait_n(2);
        reset = 1'b0;
        wait_n(5);

        // Latency D+3 edges, then the full run cycle
        btn_modo = 1'b1;
        wait_n(6);
        check("lat_before", code(), 32'd0);
        wait_n(1);
        check("lat_at", code(), 32'd1);
        wait_n(3);
        btn_modo = 1'b0;
        wait_n(10);
        press_modo(10, 10);
        check("step_timer", code(), 32'd2);
        press_modo(10, 10);
        check("step_relogio", code(), 32'd0);

        // Glitches shorter than D cycles are rejected
        for (int g = 1; g <= 3; g++) begin
            for (int r = 0; r < 2; r++) begin
                btn_modo = 1'b1;
                wait_n(g);
                btn_modo = 1'b0;
                wait_n(8);
            end
        end
        check("glitch", code(), 32'd0);

        // Bouncing press gives exactly one step
        btn_modo = 1'b1; wait_n(1);
        btn_modo = 1'b0; wait_n(1);
        btn_modo = 1'b1; wait_n(1);
        btn_modo = 1'b0; wait_n(1);
        press_modo(10, 10);
        check("bounce", code(), 32'd1);

        // CRONOMETRO ignores adjust; TIMER long press enters AJUSTE_TIMER
        press_ajuste(30, 10);
        check("cron_adj_ign", code(), 32'd1);
        press_modo(10, 10);
        check("to_timer", code(), 32'd2);
        p0 = pulse_cnt;
        press_ajuste(30, 10);
        check("timer_long", code(), 32'd6);
        press_modo(10, 10);
        check("adj_modo_ign", code(), 32'd6);
        check("entry_no_pulse_t", 32'(pulse_cnt - p0), 32'd0);
        exit_adj("exit_timer", 32'd6, 32'd2);
        press_modo(10, 10);
        check("back_relogio", code(), 32'd0);

        // Long press timing from RELOGIO: raw edge + 6 + 16
        p0 = pulse_cnt;
        btn_ajuste = 1'b1;
        wait_n(21);
        check("long_before", code(), 32'd0);
        wait_n(1);
        check("long_at", code(), 32'd4);
        check("long_pulse", 32'(pulso_saida_ajuste), 32'd0);
        wait_n(8);
        btn_ajuste = 1'b0;
        wait_n(10);
        check("release_no_exit", code(), 32'd4);
        check("entry_no_pulse_r", 32'(pulse_cnt - p0), 32'd0);
        exit_adj("exit_relogio", 32'd4, 32'd0);

        // Simultaneous rises in AJUSTE_RELOGIO: adjust wins, mode rise discarded
        press_ajuste(30, 10);
        check("simul_enter", code(), 32'd4);
        p0 = pulse_cnt;
        btn_modo   = 1'b1;
        btn_ajuste = 1'b1;
        wait_n(10);
        btn_modo   = 1'b0;
        btn_ajuste = 1'b0;
        wait_n(10);
        check("simul_code", code(), 32'd0);
        check("simul_pulse", 32'(pulse_cnt - p0), 32'd1);

        // Reset at hold count 10 discards the hold progress
        btn_ajuste = 1'b1;
        wait_n(16);
        #2 reset = 1'b1;
        #1 check("hold_rst", code(), 32'd0);
        wait_n(1);
        btn_ajuste = 1'b0;
        wait_n(2);
        reset = 1'b0;
        wait_n(5);
        btn_ajuste = 1'b1;
        wait_n(21);
        check("rehold_before", code(), 32'd0);
        wait_n(1);
        check("rehold_at", code(), 32'd4);

`ifdef SELETOR_AUTO_EXIT_EN
        // Buttons still: timeout exit exactly A cycles after entry
        p0 = pulse_cnt;
        wait_n(A - 1);
        check("auto_before", code(), 32'd4);
        wait_n(1);
        check("auto_code", code(), 32'd0);
        check("auto_pulse", 32'(pulso_saida_ajuste), 32'd1);
        btn_ajuste = 1'b0;
        wait_n(10);
        check("auto_one_pulse", 32'(pulse_cnt - p0), 32'd1);
`else
        wait_n(8);
        btn_ajuste = 1'b0;
        wait_n(200);
        check("no_auto_exit", code(), 32'd4);
        exit_adj("exit_late", 32'd4, 32'd0);
`endif

        // Mode button held through reset produces no rise until re-pressed
        btn_modo = 1'b1;
        wait_n(2);
        #2 reset = 1'b1;
        wait_n(3);
        reset = 1'b0;
        wait_n(20);
        check("held_rst", code(), 32'd0);
        btn_modo = 1'b0;
        wait_n(10);
        press_modo(10, 10);
        check("after_held", code(), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seletor_modo.md
Name: seletor_modo

Overview:
- Push-button mode sequencer for the digital clock.
- Produces the 3-bit mode code {SW2,SW1,SW0} that the mode decoder consumes, so the board can run from two buttons instead of three slide switches.
- Debounces both buttons, cycles the run modes on short presses, and enters or exits adjust modes via the adjust button.
- Sits between the board push-buttons and the mode decoder inputs.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a synchronized button level is accepted (10 ms at 50 MHz).
- LONG_PRESS_CYCLES, 100000000: cycles the debounced adjust button must stay high to enter an adjust mode (2 s at 50 MHz).
- AUTO_EXIT_CYCLES, 500000000: inactivity timeout used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_modo  input  1  raw mode button, active-high, asynchronous to clk.
- btn_ajuste  input  1  raw adjust button, active-high, asynchronous to clk.
- SW2  output  1  mode code bit 2.
- SW1  output  1  mode code bit 1.
- SW0  output  1  mode code bit 0.
- pulso_saida_ajuste  output  1  one-cycle pulse on the cycle the code leaves an adjust mode.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All flops use it.
- Reset values: SW2=SW1=SW0=0 (RELOGIO), pulso_saida_ajuste=0, sync flops 0, debounced levels 0, all counters 0.
- Input conditioning, per button:
  - 2-FF synchronizer, then debouncer.
  - Debounce counter increments while the synced level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the difference still present, the stable level takes the synced value and the counter clears.
  - Rise = stable is 1 now and was 0 on the previous cycle.
- Latency: a clean raw edge changes the code exactly DEBOUNCE_CYCLES+3 clock edges later. Glitches shorter than DEBOUNCE_CYCLES cycles have no effect.
- Long press:
  - Hold counter counts while stable adjust is 1 and clears when it is 0.
  - Saturates at LONG_PRESS_CYCLES.
  - A long event fires once per press, on the cycle the counter reaches LONG_PRESS_CYCLES-1.
- FSM states and registered codes: RELOGIO 000, CRONOMETRO 001, TIMER 010, AJUSTE_RELOGIO 100, AJUSTE_TIMER 110. Code 1x1 and 011 are never produced.
- Transitions:
  - RELOGIO: modo rise -> CRONOMETRO; adjust long event -> AJUSTE_RELOGIO.
  - CRONOMETRO: modo rise -> TIMER; adjust ignored.
  - TIMER: modo rise -> RELOGIO; adjust long event -> AJUSTE_TIMER.
  - AJUSTE_RELOGIO: adjust rise -> RELOGIO and pulso_saida_ajuste=1 for one cycle; modo ignored.
  - AJUSTE_TIMER: adjust rise -> TIMER and pulso_saida_ajuste=1 for one cycle; modo ignored.
- Entering an adjust mode never generates an exit. The release after a long press is not a rise, so exiting requires a new press.
- Simultaneous events: any adjust event in a cycle wins over a modo rise in the same cycle; the modo rise is discarded.
- Buttons held through reset: no rise is generated until the stable level has returned to 0 and risen again.
- Reset mid-debounce or mid-hold: all progress is discarded and the FSM returns to RELOGIO.

Optional Feature:
- Macro: SELETOR_AUTO_EXIT_EN.
- Defined:
  - An inactivity counter runs only in the adjust states.
  - It clears on entry and on any stable-level change of either button.
  - On reaching AUTO_EXIT_CYCLES-1, the FSM exits exactly as for an adjust rise, including pulso_saida_ajuste.
  - The counter holds at 0 outside the adjust states.
- Undefined: no counter is built, and the adjust states are left only by an adjust rise or by reset.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, AUTO_EXIT_CYCLES=32):
1. Reset asserted mid-run, then released -> code 000, pulse 0. Three clean modo presses (each held 10 cycles) -> codes 001, 010, 000. The first change occurs 7 edges after the raw rise.
2. btn_modo glitches of 1-3 cycles, repeated -> code stays 000. Bouncing press (toggle 3 times, then high 10 cycles) -> exactly one step to 001.
3. In RELOGIO, hold btn_ajuste 30 cycles -> code 100 at raw edge + 6 + 16 edges, with no pulse. Release, then press again -> code 000 with a one-cycle pulse.
4. In CRONOMETRO, hold btn_ajuste 30 cycles -> code stays 001. In TIMER, hold it 30 cycles -> 110. A modo press there -> stays 110. An adjust press -> 010 with a pulse.
5. In AJUSTE_RELOGIO, drive btn_modo and btn_ajuste rising on the same cycle -> 000 with a pulse; no step to 001. Assert reset while holding adjust in RELOGIO at hold count 10 -> 000, and the release plus re-hold needs the full 16 cycles again.
6. With SELETOR_AUTO_EXIT_EN defined: enter 100, keep both buttons still -> 000 with a pulse exactly 32 cycles after entry. Without the macro -> code stays 100 for 200 cycles.
